// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiplier/divider: the sequencing
// state encoding, the operation encoding, and the default iteration sizing.
// Used by the control FSM, the datapath and the bench.
package multdiv_pkg;

  localparam int unsigned CNT_W_DEF  = 6;
  localparam int unsigned N_ITER_DEF = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_POST,
    ST_DONE
  } state_e;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Handshake bundle between the multdiv sequencer and its neighbours
// (start requests, datapath flags, iteration counter, datapath strobes).
//   slave  : the sequencer (multdiv_ctrl)
//   master : the surrounding multdiv top / datapath / counter side
// Parameter CNT_W sets the width of the counter value.
interface multdiv_ctrl_if #(
  parameter int unsigned CNT_W = 6
) ();

  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             divisor_zero;
  logic             ovf_in;
  logic [CNT_W-1:0] count;
  logic             cnt_clr;
  logic             load;
  logic             step_en;
  logic             post_en;
  logic             op_div;
  logic             busy;
  logic             result_rdy;
  logic             data_exception;

  modport slave (
    input  ctrl_MULT, ctrl_DIV, divisor_zero, ovf_in, count,
    output cnt_clr, load, step_en, post_en, op_div, busy,
           result_rdy, data_exception
  );

  modport master (
    output ctrl_MULT, ctrl_DIV, divisor_zero, ovf_in, count,
    input  cnt_clr, load, step_en, post_en, op_div, busy,
           result_rdy, data_exception
  );

endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencing FSM for the iterative multiplier/divider.
// Consumes the iteration count, drives the counter clear, and issues
// load/step/post strobes; reports result_rdy and data_exception.
// Ports:
//   clock  : single clock, rising edge
//   clr_n  : asynchronous active-low reset
//   bus    : multdiv_ctrl_if.slave (starts, datapath flags, count in;
//            cnt_clr, load, step_en, post_en, op_div, busy,
//            result_rdy, data_exception out)
// Build option: MULTDIV_RESTART_EN lets a start while busy abort the
// running operation and reload; without it such starts are dropped.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned N_ITER = N_ITER_DEF
) (
  input  logic           clock,
  input  logic           clr_n,
  multdiv_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

  state_e state_q, state_d;
  logic   exc_q, exc_d;
  logic   opdiv_q, opdiv_d;

  logic   cnt_clr_q, load_q, step_q, post_q, busy_q, rdy_q, dexc_q;

  logic   start_one, start_both, restart_en;

  assign start_one  = bus.ctrl_MULT ^ bus.ctrl_DIV;
  assign start_both = bus.ctrl_MULT & bus.ctrl_DIV;

`ifdef MULTDIV_RESTART_EN
  assign restart_en = (state_q == ST_LOAD) || (state_q == ST_RUN) ||
                      (state_q == ST_POST);
`else
  assign restart_en = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    opdiv_d = opdiv_q;
    // Abort while busy takes priority over the normal per-state sequencing.
    if (restart_en && start_both) begin
      state_d = ST_DONE;
      exc_d   = 1'b1;
    end else if (restart_en && start_one) begin
      state_d = ST_LOAD;
      opdiv_d = bus.ctrl_DIV;
      exc_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_both) begin
            state_d = ST_DONE;
            exc_d   = 1'b1;
          end else if (start_one) begin
            state_d = ST_LOAD;
            opdiv_d = bus.ctrl_DIV;
          end
        end
        ST_LOAD: begin
          if ((opdiv_q == OP_DIV) && bus.divisor_zero) begin
            state_d = ST_DONE;
            exc_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // >= so a counter that overshoots still terminates the run.
          if (bus.count >= LAST_CNT) state_d = ST_POST;
        end
        ST_POST: begin
          exc_d   = bus.ovf_in;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          exc_d = 1'b0;
          if (start_one) begin
            state_d = ST_LOAD;
            opdiv_d = bus.ctrl_DIV;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          exc_d   = 1'b0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they are
  // aligned with state_q in every cycle.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= ST_IDLE;
      exc_q     <= 1'b0;
      opdiv_q   <= OP_MULT;
      cnt_clr_q <= 1'b1;
      load_q    <= 1'b0;
      step_q    <= 1'b0;
      post_q    <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      dexc_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      exc_q     <= exc_d;
      opdiv_q   <= opdiv_d;
      cnt_clr_q <= (state_d != ST_RUN);
      load_q    <= (state_d == ST_LOAD);
      step_q    <= (state_d == ST_RUN);
      post_q    <= (state_d == ST_POST);
      busy_q    <= (state_d == ST_LOAD) || (state_d == ST_RUN) ||
                   (state_d == ST_POST);
      rdy_q     <= (state_d == ST_DONE);
      dexc_q    <= (state_d == ST_DONE) && exc_d;
    end
  end

  assign bus.cnt_clr        = cnt_clr_q;
  assign bus.load           = load_q;
  assign bus.step_en        = step_q;
  assign bus.post_en        = post_q;
  assign bus.op_div         = opdiv_q;
  assign bus.busy           = busy_q;
  assign bus.result_rdy     = rdy_q;
  assign bus.data_exception = dexc_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl with a scoreboard of expected
// result_rdy cycles, exception flags and latched operation, plus a
// behavioural iteration counter wired to count/cnt_clr.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  localparam int unsigned CW = CNT_W_DEF;
  localparam int unsigned NI = N_ITER_DEF;
  localparam int          LAT = NI + 2;

  logic clock = 1'b0;
  logic clr_n = 1'b1;

  multdiv_ctrl_if #(.CNT_W(CW)) mif ();

  multdiv_ctrl #(.CNT_W(CW), .N_ITER(NI)) dut (
    .clock (clock),
    .clr_n (clr_n),
    .bus   (mif)
  );

  always #5 clock = ~clock;

  // Iteration counter that sits beside the sequencer.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n)           mif.count <= '0;
    else if (mif.cnt_clr) mif.count <= '0;
    else                  mif.count <= mif.count + 1'b1;
  end

  typedef struct {
    int   cyc;
    logic exc;
    logic opd;
  } exp_t;

  exp_t sb[$];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  int   n_load = 0, n_step = 0, n_post = 0;
  logic prev_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outv();
    return {mif.cnt_clr, mif.load, mif.step_en, mif.post_en,
            mif.op_div, mif.busy, mif.result_rdy, mif.data_exception};
  endfunction

  // Monitor: strobe counts, result scoreboard, single-cycle result pulse.
  always @(negedge clock) begin
    exp_t e;
    if (!clr_n) begin
      prev_rdy = 1'b0;
    end else begin
      if (mif.load)    n_load++;
      if (mif.step_en) n_step++;
      if (mif.post_en) n_post++;
      if (prev_rdy) begin
        chk("rdy_pulse", {31'd0, mif.result_rdy}, 32'd0);
        chk("exc_after_rdy", {31'd0, mif.data_exception}, 32'd0);
      end
      if (mif.result_rdy) begin
        if (sb.size() == 0) begin
          chk("spurious_rdy", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rdy_cycle", cyc, e.cyc);
          chk("rdy_exc", {31'd0, mif.data_exception}, {31'd0, e.exc});
          chk("rdy_opdiv", {31'd0, mif.op_div}, {31'd0, e.opd});
        end
      end
      prev_rdy = mif.result_rdy;
    end
  end

  // Drive a start at the current (negedge) time; optionally record the
  // expected result offset from the sampling edge.
  task automatic start(input logic m, input logic d, input int off,
                       input logic exc, input logic opd, output int e0);
    exp_t e;
    mif.ctrl_MULT = m;
    mif.ctrl_DIV  = d;
    @(posedge clock);
    #1;
    e0 = cyc;
    mif.ctrl_MULT = 1'b0;
    mif.ctrl_DIV  = 1'b0;
    if (off >= 0) begin
      e.cyc = e0 + off;
      e.exc = exc;
      e.opd = opd;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((sb.size() != 0 || mif.busy) && n < maxc) begin
      @(negedge clock);
      n++;
    end
    if (n >= maxc) chk("drain_timeout", 32'd1, 32'd0);
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic wait_count(input int val);
    int n = 0;
    @(negedge clock);
    while (!(mif.step_en && mif.count == CW'(val)) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("count_timeout", 32'd1, 32'd0);
  endtask

  task automatic clr_strobes();
    n_load = 0;
    n_step = 0;
    n_post = 0;
  endtask

  initial begin
    int e0, e1, n;
    mif.ctrl_MULT    = 1'b0;
    mif.ctrl_DIV     = 1'b0;
    mif.divisor_zero = 1'b0;
    mif.ovf_in       = 1'b0;
    #1 clr_n = 1'b0;
    #11;
    chk("reset_outputs", {24'd0, outv()}, {24'd0, 8'b1000_0000});
    @(negedge clock) clr_n = 1'b1;
    @(negedge clock);

    // Multiply, no overflow.
    clr_strobes();
    start(1'b1, 1'b0, LAT, 1'b0, OP_MULT, e0);
    wait_drain(100);
    chk("mult_load_cycles", n_load, 32'd1);
    chk("mult_step_cycles", n_step, NI);
    chk("mult_post_cycles", n_post, 32'd1);

    // Divide by zero.
    clr_strobes();
    mif.divisor_zero = 1'b1;
    start(1'b0, 1'b1, 1, 1'b1, OP_DIV, e0);
    wait_drain(20);
    mif.divisor_zero = 1'b0;
    chk("dz_step_cycles", n_step, 32'd0);

    // Multiply with overflow flagged (held high throughout).
    mif.ovf_in = 1'b1;
    start(1'b1, 1'b0, LAT, 1'b1, OP_MULT, e0);
    wait_drain(100);
    mif.ovf_in = 1'b0;

    // Both starts in IDLE: illegal request, op_div unchanged.
    start(1'b1, 1'b1, 0, 1'b1, OP_MULT, e0);
    @(negedge clock);
    @(negedge clock);
    chk("idle_after_illegal", {29'd0, mif.cnt_clr, mif.busy, mif.load}, 32'b100);

    // Asynchronous reset mid-run, then a full divide.
    start(1'b1, 1'b0, LAT, 1'b0, OP_MULT, e0);
    wait_count(17);
    #2 clr_n = 1'b0;
    #1;
    chk("async_reset_outputs", {24'd0, outv()}, {24'd0, 8'b1000_0000});
    sb.delete();
    @(negedge clock) clr_n = 1'b1;
    @(negedge clock);
    start(1'b0, 1'b1, LAT, 1'b0, OP_DIV, e0);
    wait_drain(100);

    // Start while running.
    start(1'b1, 1'b0, LAT, 1'b0, OP_MULT, e0);
    wait_count(10);
`ifdef MULTDIV_RESTART_EN
    void'(sb.pop_back());
    start(1'b0, 1'b1, LAT, 1'b0, OP_DIV, e1);
    chk("restart_load", {30'd0, mif.load, mif.op_div}, 32'b11);
`else
    start(1'b0, 1'b1, -1, 1'b0, OP_DIV, e1);
    chk("busy_start_dropped", {30'd0, mif.step_en, mif.op_div}, 32'b10);
`endif
    wait_drain(100);

    // Back-to-back: start presented in DONE.
    start(1'b1, 1'b0, LAT, 1'b0, OP_MULT, e0);
    n = 0;
    while (!mif.result_rdy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("b2b_rdy_timeout", 32'd1, 32'd0);
    start(1'b0, 1'b1, LAT, 1'b0, OP_DIV, e1);
    chk("b2b_load", {29'd0, mif.load, mif.busy, mif.op_div}, 32'b111);
    wait_drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
